// File: rtl/fifo_word_serializer.sv
// Pops DW-bit words from a show-ahead FIFO and emits them as OW-bit
// chunks, LSB first, on a valid/ready stream with no inter-word bubble.
module fifo_word_serializer #(
    parameter int DW = 32,
    parameter int OW = 8,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          ARst,
    input  logic          En,
    input  logic          Abort,
    input  logic [DW-1:0] FifoData,
    input  logic          FifoEty,
    output logic          FifoRd,
    output logic [OW-1:0] OutData,
    output logic          OutValid,
    input  logic          OutReady,
    output logic          OutLast,
    output logic          Busy,
    output logic [CW-1:0] WordCount
);

    localparam int NCH = DW / OW;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_n;
    logic [DW-1:0] sh, sh_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] wcnt, wcnt_n;
    logic          fire, last, pop_ok, rd;

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            state <= IDLE;
            sh    <= '0;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            idx   <= idx_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        fire    = (state == SEND) & OutReady;
        last    = (idx == LAST);
        // ARst gates the pop so the FIFO is never drained while held in reset
        pop_ok  = En & ~FifoEty & ~Abort & ~ARst;
        rd      = pop_ok & ((state == IDLE) | (fire & last));
        state_n = state;
        sh_n    = sh;
        idx_n   = idx;
        wcnt_n  = wcnt;
        if (fire & last)
            wcnt_n = wcnt + CW'(1);
        if (rd) begin
            sh_n    = FifoData;
            idx_n   = '0;
            state_n = SEND;
        end else if (Abort) begin
            idx_n   = '0;
            state_n = IDLE;
        end else if (fire) begin
            if (last) begin
                state_n = IDLE;
            end else begin
                sh_n  = sh >> OW;
                idx_n = idx + IW'(1);
            end
        end
    end

    assign FifoRd    = rd;
    assign OutValid  = (state == SEND);
    assign Busy      = OutValid;
    assign OutData   = sh[OW-1:0];
    assign OutLast   = OutValid & last;
    assign WordCount = wcnt;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench for fifo_word_serializer: a small FIFO model feeds the
// DUT, a monitor pops expected chunks from a queue on every transfer.
module tb_fifo_word_serializer;

    localparam int DW = 32;
    localparam int OW = 8;
    localparam int CW = 16;

    logic          Clk;
    logic          ARst;
    logic          En;
    logic          Abort;
    logic [DW-1:0] FifoData;
    logic          FifoEty;
    logic          FifoRd;
    logic [OW-1:0] OutData;
    logic          OutValid;
    logic          OutReady;
    logic          OutLast;
    logic          Busy;
    logic [CW-1:0] WordCount;

    fifo_word_serializer #(.DW(DW), .OW(OW), .CW(CW)) dut (
        .Clk(Clk),
        .ARst(ARst),
        .En(En),
        .Abort(Abort),
        .FifoData(FifoData),
        .FifoEty(FifoEty),
        .FifoRd(FifoRd),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .OutLast(OutLast),
        .Busy(Busy),
        .WordCount(WordCount)
    );

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mem [0:15];
    int wp = 0;
    int rp = 0;
    logic rd_q = 1'b0;
    int rd_cnt = 0;

    logic [OW:0] exp_q [$];
    int vcyc = 0;
    int xcnt = 0;
    int lastrd = 0;
    logic hold_v = 1'b0;
    logic [OW:0] hold_d;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    assign FifoEty  = (wp == rp);
    assign FifoData = mem[rp[3:0]];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    always @(negedge Clk) begin
        rd_q = FifoRd;
        if (FifoRd) begin
            rd_cnt++;
            chk("underflow", FifoEty, 0);
        end
    end

    always @(posedge Clk) begin
        if (rd_q) rp <= rp + 1;
    end

    always @(negedge Clk) begin
        if (ARst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && OutValid)
                chk("hold", {OutLast, OutData}, hold_d);
            if (OutValid) vcyc++;
            if (OutValid && OutReady) begin
                xcnt++;
                if (OutLast && FifoRd) lastrd++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_chunk: got=%0h want=none", {OutLast, OutData});
                end else begin
                    chk("chunk", {OutLast, OutData}, exp_q.pop_front());
                end
            end
            hold_v = OutValid && !OutReady;
            hold_d = {OutLast, OutData};
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic fifo_push(input logic [DW-1:0] w);
        mem[wp[3:0]] = w;
        wp++;
    endtask

    task automatic exp_push(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == DW/OW - 1), w[OW*i +: OW]});
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || OutValid) && t < 100) begin
            cyc();
            t++;
        end
        if (t >= 100) chk("drain_timeout", 1, 0);
    endtask

    task automatic wait_x(input int target);
        int t = 0;
        while (xcnt < target && t < 100) begin
            cyc();
            t++;
        end
        if (t >= 100) chk("xfer_timeout", 1, 0);
    endtask

    int r0, v0, l0, x0;

    initial begin
        ARst = 1'b1;
        En = 1'b0;
        Abort = 1'b0;
        OutReady = 1'b1;
        repeat (3) cyc();
        chk("rst_valid", OutValid, 0);
        chk("rst_data", OutData, 0);
        chk("rst_last", OutLast, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_wc", WordCount, 0);

        // single word, pending while still in reset
        En = 1'b1;
        fifo_push(32'hA1B2C3D4);
        exp_push(32'hA1B2C3D4, 4);
        #2;
        chk("rst_rd", FifoRd, 0);
        cyc();
        r0 = rd_cnt;
        v0 = vcyc;
        ARst = 1'b0;
        wait_drain();
        chk("t1_rd", rd_cnt - r0, 1);
        chk("t1_vcyc", vcyc - v0, 4);
        chk("t1_wc", WordCount, 1);

        // back-to-back words, no bubble
        r0 = rd_cnt;
        v0 = vcyc;
        l0 = lastrd;
        fifo_push(32'h11223344);
        fifo_push(32'h55667788);
        exp_push(32'h11223344, 4);
        exp_push(32'h55667788, 4);
        wait_drain();
        chk("t2_rd", rd_cnt - r0, 2);
        chk("t2_vcyc", vcyc - v0, 8);
        chk("t2_lastrd", lastrd - l0, 1);
        chk("t2_wc", WordCount, 3);

        // backpressure
        fifo_push(32'hDEADBEEF);
        exp_push(32'hDEADBEEF, 4);
        for (int i = 0; i < 12; i++) begin
            OutReady = (i % 4 == 0) || (i % 4 == 3);
            cyc();
        end
        OutReady = 1'b1;
        wait_drain();
        chk("t3_wc", WordCount, 4);

        // En dropped mid-word
        r0 = rd_cnt;
        fifo_push(32'h01020304);
        exp_push(32'h01020304, 4);
        cyc();
        En = 1'b0;
        fifo_push(32'h0A0B0C0D);
        wait_drain();
        repeat (3) cyc();
        chk("t4_rd_hold", rd_cnt - r0, 1);
        chk("t4_wc", WordCount, 5);
        chk("t4_ety", FifoEty, 0);
        exp_push(32'h0A0B0C0D, 4);
        En = 1'b1;
        wait_drain();
        chk("t4_rd", rd_cnt - r0, 2);
        chk("t4_wc2", WordCount, 6);

        // Abort after two chunks
        x0 = xcnt;
        fifo_push(32'hCAFEF00D);
        exp_push(32'hCAFEF00D, 2);
        wait_x(x0 + 2);
        Abort = 1'b1;
        OutReady = 1'b0;
        fifo_push(32'h12345678);
        #1;
        chk("abort_rd", FifoRd, 0);
        cyc();
        Abort = 1'b0;
        chk("abort_valid", OutValid, 0);
        chk("abort_wc", WordCount, 6);
        OutReady = 1'b1;
        exp_push(32'h12345678, 4);
        wait_drain();
        chk("t5_wc", WordCount, 7);

        // asynchronous reset mid-word
        x0 = xcnt;
        fifo_push(32'h99887766);
        exp_push(32'h99887766, 4);
        wait_x(x0 + 1);
        ARst = 1'b1;
        #1;
        chk("arst_valid", OutValid, 0);
        chk("arst_last", OutLast, 0);
        chk("arst_data", OutData, 0);
        chk("arst_wc", WordCount, 0);
        exp_q.delete();
        repeat (2) cyc();
        ARst = 1'b0;
        r0 = rd_cnt;
        repeat (5) cyc();
        chk("arst_no_rd", rd_cnt - r0, 0);
        chk("arst_idle", OutValid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
